// File: rtl/ifu_ic_way_ctl_if.sv
// ---------------------------------------------------------------------------
// ifu_ic_way_ctl_if
// Groups every signal between the way controller, the IFU miss logic, the
// tag array and the debug port into one bundle.
//
// modport slave  : the way controller (ifu_ic_way_ctl)
// modport master : the surrounding IFU / tag array / debug logic
//
// Parameters:
//   INDEX_W : set-index width (2^INDEX_W sets)
//   CNT_W   : width of the tag-parity error counter
//
// Signal summary:
//   io_ic_rw_addr          lookup/fill address (addr[31:3])
//   io_ic_rd_en            tag lookup issued this cycle
//   io_ic_rd_hit           per-way hit, valid the cycle after io_ic_rd_en
//   io_ic_tag_perr         tag parity error, same timing as io_ic_rd_hit
//   io_ic_tag_valid        valid bits of the set at io_ic_rw_addr
//   io_ic_wr_en            one-hot tag write strobe
//   io_wr_index            set index being filled
//   io_miss_start          start a fill for io_ic_rw_addr
//   io_fill_done           line fill complete
//   io_fill_err            bus error on fill, abort
//   io_ic_inv_all          invalidate the whole cache
//   io_ic_debug_*          debug write port (bit 0 of data = valid value)
//   io_busy                fill machine not idle
//   io_victim_way          latched one-hot victim
//   io_perr_cnt            saturating tag parity error count
// ---------------------------------------------------------------------------
interface ifu_ic_way_ctl_if #(
  parameter int INDEX_W = 7,
  parameter int CNT_W   = 16
);
  logic [28:0]        io_ic_rw_addr;
  logic               io_ic_rd_en;
  logic [1:0]         io_ic_rd_hit;
  logic               io_ic_tag_perr;
  logic [1:0]         io_ic_tag_valid;
  logic [1:0]         io_ic_wr_en;
  logic [INDEX_W-1:0] io_wr_index;
  logic               io_miss_start;
  logic               io_fill_done;
  logic               io_fill_err;
  logic               io_ic_inv_all;
  logic               io_ic_debug_wr_en;
  logic               io_ic_debug_tag_array;
  logic [1:0]         io_ic_debug_way;
  logic [9:0]         io_ic_debug_addr;
  logic [70:0]        io_ic_debug_wr_data;
  logic               io_busy;
  logic [1:0]         io_victim_way;
  logic [CNT_W-1:0]   io_perr_cnt;

  modport slave (
    input  io_ic_rw_addr, io_ic_rd_en, io_ic_rd_hit, io_ic_tag_perr,
    input  io_miss_start, io_fill_done, io_fill_err, io_ic_inv_all,
    input  io_ic_debug_wr_en, io_ic_debug_tag_array, io_ic_debug_way,
    input  io_ic_debug_addr, io_ic_debug_wr_data,
    output io_ic_tag_valid, io_ic_wr_en, io_wr_index, io_busy,
    output io_victim_way, io_perr_cnt
  );

  modport master (
    output io_ic_rw_addr, io_ic_rd_en, io_ic_rd_hit, io_ic_tag_perr,
    output io_miss_start, io_fill_done, io_fill_err, io_ic_inv_all,
    output io_ic_debug_wr_en, io_ic_debug_tag_array, io_ic_debug_way,
    output io_ic_debug_addr, io_ic_debug_wr_data,
    input  io_ic_tag_valid, io_ic_wr_en, io_wr_index, io_busy,
    input  io_victim_way, io_perr_cnt
  );
endinterface

// File: rtl/ifu_ic_way_ctl.sv
// ---------------------------------------------------------------------------
// ifu_ic_way_ctl
// Valid-bit and LRU replacement controller for a 2-way instruction-cache tag
// array. Holds per-set valid bits and an LRU bit, consumes lookup results one
// cycle after each lookup, and runs the miss-fill victim-selection FSM.
//
// Ports:
//   clock : core clock
//   reset : synchronous, active-high reset
//   ic    : ifu_ic_way_ctl_if.slave bundle (lookup, fill, debug, status)
//
// Optional feature: define IC_TAG_PERR_CNT_EN to build the saturating tag
// parity error counter; otherwise io_perr_cnt is tied to zero.
// ---------------------------------------------------------------------------
module ifu_ic_way_ctl #(
  parameter int INDEX_W = 7,
  parameter int CNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  ifu_ic_way_ctl_if.slave     ic
);
  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SETS-1:0]    valid0_q, valid1_q, lru_q;
  logic               rd_vld_q;
  logic [INDEX_W-1:0] rd_idx_q;
  logic [INDEX_W-1:0] fill_idx_q;
  logic [1:0]         victim_q;

  logic [INDEX_W-1:0] rw_idx;
  logic [INDEX_W-1:0] dbg_idx;
  logic               dbg_wr;
  logic               fill_start;
  logic               fill_write;
  logic [1:0]         victim_d;
  logic               unused_ok;

  assign rw_idx  = ic.io_ic_rw_addr[INDEX_W+2:3];
  assign dbg_idx = ic.io_ic_debug_addr[INDEX_W-1:0];
  assign dbg_wr  = ic.io_ic_debug_wr_en & ic.io_ic_debug_tag_array;

  // Address and debug bits outside the set index are not needed here.
  assign unused_ok = &{1'b0, ic.io_ic_rw_addr, ic.io_ic_debug_addr,
                       ic.io_ic_debug_wr_data[70:1]};

  // Victim choice: first invalid way wins, otherwise the LRU pointer decides.
  always_comb begin
    victim_d = 2'b01;
    if (!valid0_q[rw_idx]) begin
      victim_d = 2'b01;
    end else if (!valid1_q[rw_idx]) begin
      victim_d = 2'b10;
    end else if (lru_q[rw_idx]) begin
      victim_d = 2'b10;
    end
  end

  // Fill FSM next state. inv_all abandons any fill in progress.
  always_comb begin
    state_d    = state_q;
    fill_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (ic.io_miss_start) begin
          state_d    = FILL;
          fill_start = 1'b1;
        end
      end
      FILL: begin
        if (ic.io_fill_err) begin
          state_d = IDLE;
        end else if (ic.io_fill_done) begin
          state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ic.io_ic_inv_all) begin
      state_d    = IDLE;
      fill_start = 1'b0;
    end
  end

  assign fill_write = (state_q == WRITE) && !ic.io_ic_inv_all;

  // FSM state, latched fill index and victim.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fill_idx_q <= '0;
      victim_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (fill_start) begin
        fill_idx_q <= rw_idx;
        victim_q   <= victim_d;
      end
    end
  end

  // Lookup pipeline: results arrive one cycle after the lookup.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= ic.io_ic_rd_en;
      if (ic.io_ic_rd_en) begin
        rd_idx_q <= rw_idx;
      end
    end
  end

  // Valid/LRU update. Sources are applied lowest priority first so a later
  // assignment to the same bit overrides an earlier one:
  // lookup result < debug write < fill write < inv_all.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (rd_vld_q) begin
        if (ic.io_ic_tag_perr || (ic.io_ic_rd_hit == 2'b11)) begin
          valid0_q[rd_idx_q] <= 1'b0;
          valid1_q[rd_idx_q] <= 1'b0;
        end else if (ic.io_ic_rd_hit == 2'b01) begin
          lru_q[rd_idx_q] <= 1'b1;
        end else if (ic.io_ic_rd_hit == 2'b10) begin
          lru_q[rd_idx_q] <= 1'b0;
        end
      end
      if (dbg_wr) begin
        if (ic.io_ic_debug_way[0]) begin
          valid0_q[dbg_idx] <= ic.io_ic_debug_wr_data[0];
        end
        if (ic.io_ic_debug_way[1]) begin
          valid1_q[dbg_idx] <= ic.io_ic_debug_wr_data[0];
        end
      end
      if (fill_write) begin
        if (victim_q[0]) begin
          valid0_q[fill_idx_q] <= 1'b1;
        end
        if (victim_q[1]) begin
          valid1_q[fill_idx_q] <= 1'b1;
        end
        // Filling way0 makes way1 the next victim and vice versa.
        lru_q[fill_idx_q] <= victim_q[0];
      end
      if (ic.io_ic_inv_all) begin
        valid0_q <= '0;
        valid1_q <= '0;
      end
    end
  end

`ifdef IC_TAG_PERR_CNT_EN
  logic [CNT_W-1:0] perr_cnt_q;

  // Saturating parity error counter, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      perr_cnt_q <= '0;
    end else if (rd_vld_q && ic.io_ic_tag_perr && (perr_cnt_q != '1)) begin
      perr_cnt_q <= perr_cnt_q + 1'b1;
    end
  end

  assign ic.io_perr_cnt = perr_cnt_q;
`else
  assign ic.io_perr_cnt = '0;
`endif

  assign ic.io_ic_tag_valid = {valid1_q[rw_idx], valid0_q[rw_idx]};
  assign ic.io_ic_wr_en     = fill_write ? victim_q : 2'b00;
  assign ic.io_wr_index     = fill_idx_q;
  assign ic.io_busy         = (state_q != IDLE);
  assign ic.io_victim_way   = victim_q;

endmodule

// File: tb/tb_ifu_ic_way_ctl.sv
// ---------------------------------------------------------------------------
// tb_ifu_ic_way_ctl
// Self-checking bench for ifu_ic_way_ctl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model of
// the valid/LRU arrays and the fill sequence.
// ---------------------------------------------------------------------------
module tb_ifu_ic_way_ctl;
  localparam int INDEX_W = 7;
  localparam int CNT_W   = 16;
  localparam int SETS    = 1 << INDEX_W;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ifu_ic_way_ctl_if #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) ic ();

  ifu_ic_way_ctl #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .ic    (ic)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  bit       mv0 [SETS];
  bit       mv1 [SETS];
  bit       ml  [SETS];
  int       m_phase;      // 0 idle, 1 waiting for line, 2 writing tag
  int       m_idx;
  bit [1:0] m_vict;
  bit       m_rd_pend;
  int       m_rd_idx;
  int       m_perr;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int curIdx();
    return int'(ic.io_ic_rw_addr[INDEX_W+2:3]);
  endfunction

  task automatic setAddr(input int idx);
    logic [28:0] a;
    a = 29'($urandom);
    a[INDEX_W+2:3] = INDEX_W'(idx);
    ic.io_ic_rw_addr = a;
  endtask

  task automatic clearInputs();
    ic.io_ic_rd_en           = 1'b0;
    ic.io_ic_rd_hit          = 2'b00;
    ic.io_ic_tag_perr        = 1'b0;
    ic.io_miss_start         = 1'b0;
    ic.io_fill_done          = 1'b0;
    ic.io_fill_err           = 1'b0;
    ic.io_ic_inv_all         = 1'b0;
    ic.io_ic_debug_wr_en     = 1'b0;
    ic.io_ic_debug_tag_array = 1'b0;
    ic.io_ic_debug_way       = 2'b00;
    ic.io_ic_debug_addr      = 10'd0;
    ic.io_ic_debug_wr_data   = '0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < SETS; i++) begin
      mv0[i] = 1'b0;
      mv1[i] = 1'b0;
      ml[i]  = 1'b0;
    end
    m_phase   = 0;
    m_idx     = 0;
    m_vict    = 2'b00;
    m_rd_pend = 1'b0;
    m_rd_idx  = 0;
    m_perr    = 0;
  endtask

  // Compare all outputs against what the model says for the current inputs.
  task automatic checkModel();
    int       idx;
    bit [1:0] exp_wr;
    int       exp_cnt;
    idx    = curIdx();
    exp_wr = (m_phase == 2 && !ic.io_ic_inv_all) ? m_vict : 2'b00;
    checkOutput("tag_valid", 32'(ic.io_ic_tag_valid), 32'({mv1[idx], mv0[idx]}));
    checkOutput("busy", 32'(ic.io_busy), 32'(m_phase != 0));
    checkOutput("wr_en", 32'(ic.io_ic_wr_en), 32'(exp_wr));
    if (exp_wr != 2'b00) begin
      checkOutput("wr_index", 32'(ic.io_wr_index), 32'(m_idx));
    end
    if (m_phase != 0) begin
      checkOutput("victim_way", 32'(ic.io_victim_way), 32'(m_vict));
    end
`ifdef IC_TAG_PERR_CNT_EN
    exp_cnt = m_perr;
`else
    exp_cnt = 0;
`endif
    checkOutput("perr_cnt", 32'(ic.io_perr_cnt), 32'(exp_cnt));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  // Updates are applied in rising priority so the strongest source wins.
  task automatic modelUpdate();
    int       idx;
    int       d_idx;
    bit [1:0] pick;
    bit       inv;
    if (reset) begin
      modelReset();
      return;
    end
    idx   = curIdx();
    d_idx = int'(ic.io_ic_debug_addr) % SETS;
    inv   = ic.io_ic_inv_all;
    if (!mv0[idx])      pick = 2'b01;
    else if (!mv1[idx]) pick = 2'b10;
    else                pick = ml[idx] ? 2'b10 : 2'b01;

    if (m_rd_pend) begin
      if (ic.io_ic_tag_perr) begin
        if (m_perr < (1 << CNT_W) - 1) m_perr++;
        mv0[m_rd_idx] = 1'b0;
        mv1[m_rd_idx] = 1'b0;
      end else if (ic.io_ic_rd_hit == 2'b11) begin
        mv0[m_rd_idx] = 1'b0;
        mv1[m_rd_idx] = 1'b0;
      end else if (ic.io_ic_rd_hit == 2'b01) begin
        ml[m_rd_idx] = 1'b1;
      end else if (ic.io_ic_rd_hit == 2'b10) begin
        ml[m_rd_idx] = 1'b0;
      end
    end
    if (ic.io_ic_debug_wr_en && ic.io_ic_debug_tag_array) begin
      if (ic.io_ic_debug_way[0]) mv0[d_idx] = ic.io_ic_debug_wr_data[0];
      if (ic.io_ic_debug_way[1]) mv1[d_idx] = ic.io_ic_debug_wr_data[0];
    end
    if (m_phase == 2 && !inv) begin
      if (m_vict == 2'b01) begin
        mv0[m_idx] = 1'b1;
        ml[m_idx]  = 1'b1;
      end else begin
        mv1[m_idx] = 1'b1;
        ml[m_idx]  = 1'b0;
      end
    end
    if (inv) begin
      for (int i = 0; i < SETS; i++) begin
        mv0[i] = 1'b0;
        mv1[i] = 1'b0;
      end
    end

    if (inv) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (ic.io_miss_start) begin
        m_phase = 1;
        m_idx   = idx;
        m_vict  = pick;
      end
    end else if (m_phase == 1) begin
      if (ic.io_fill_err)       m_phase = 0;
      else if (ic.io_fill_done) m_phase = 2;
    end else begin
      m_phase = 0;
    end

    m_rd_pend = ic.io_ic_rd_en;
    if (ic.io_ic_rd_en) m_rd_idx = idx;
  endtask

  // One clock: settle, compare, advance model, move to the next negedge.
  task automatic applyStimulus();
    #1;
    checkModel();
    modelUpdate();
    @(negedge clock);
  endtask

  task automatic runFill(input int idx);
    clearInputs();
    setAddr(idx);
    ic.io_miss_start = 1'b1;
    applyStimulus();
    clearInputs();
    ic.io_fill_done = 1'b1;
    applyStimulus();
    clearInputs();
  endtask

  task automatic randomInputs();
    int idx;
    idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, SETS - 1))
                                      : int'($urandom_range(0, 3));
    setAddr(idx);
    reset                    = ($urandom_range(0, 299) == 0);
    ic.io_ic_rd_en           = ($urandom_range(0, 9) < 4);
    ic.io_ic_rd_hit          = 2'($urandom);
    ic.io_ic_tag_perr        = ($urandom_range(0, 9) == 0);
    ic.io_miss_start         = ($urandom_range(0, 4) == 0);
    ic.io_fill_done          = ($urandom_range(0, 9) < 3);
    ic.io_fill_err           = ($urandom_range(0, 19) == 0);
    ic.io_ic_inv_all         = ($urandom_range(0, 49) == 0);
    ic.io_ic_debug_wr_en     = ($urandom_range(0, 9) == 0);
    ic.io_ic_debug_tag_array = 1'($urandom);
    ic.io_ic_debug_way       = $urandom_range(0, 1) ? 2'b10 : 2'b01;
    ic.io_ic_debug_addr      = {3'($urandom), 7'($urandom_range(0, 3))};
    ic.io_ic_debug_wr_data   = {7'($urandom), $urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1;
    ic.io_ic_rw_addr = '0;
    clearInputs();
    repeat (3) @(negedge clock);
    modelReset();
    reset = 1'b0;

    // Reset state
    setAddr(0);
    #1;
    checkOutput("rst_valid_idx0", 32'(ic.io_ic_tag_valid), 32'd0);
    checkOutput("rst_busy", 32'(ic.io_busy), 32'd0);
    checkOutput("rst_wr_en", 32'(ic.io_ic_wr_en), 32'd0);
    setAddr(127);
    #1;
    checkOutput("rst_valid_idx127", 32'(ic.io_ic_tag_valid), 32'd0);
    applyStimulus();

    // Two fills of set 5 take way0 then way1
    for (int k = 0; k < 2; k++) begin
      runFill(5);
      #1;
      checkOutput("fill_wr_en", 32'(ic.io_ic_wr_en), (k == 0) ? 32'd1 : 32'd2);
      checkOutput("fill_wr_index", 32'(ic.io_wr_index), 32'd5);
      applyStimulus();
    end
    setAddr(5);
    #1;
    checkOutput("set5_full", 32'(ic.io_ic_tag_valid), 32'd3);
    applyStimulus();

    // Hit on way1 makes way0 the victim
    setAddr(5);
    ic.io_ic_rd_en = 1'b1;
    applyStimulus();
    clearInputs();
    ic.io_ic_rd_hit = 2'b10;
    applyStimulus();
    clearInputs();
    setAddr(5);
    ic.io_miss_start = 1'b1;
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("lru_victim", 32'(ic.io_victim_way), 32'd1);
    ic.io_fill_err = 1'b1;
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("abort_busy", 32'(ic.io_busy), 32'd0);

    // Parity error invalidates the set
    setAddr(5);
    ic.io_ic_rd_en = 1'b1;
    applyStimulus();
    clearInputs();
    ic.io_ic_tag_perr = 1'b1;
    ic.io_ic_rd_hit   = 2'b01;
    applyStimulus();
    clearInputs();
    setAddr(5);
    #1;
    checkOutput("perr_valid", 32'(ic.io_ic_tag_valid), 32'd0);
`ifdef IC_TAG_PERR_CNT_EN
    checkOutput("perr_cnt_one", 32'(ic.io_perr_cnt), 32'd1);
`else
    checkOutput("perr_cnt_off", 32'(ic.io_perr_cnt), 32'd0);
`endif
    applyStimulus();

    // inv_all during FILL
    runFill(20);
    applyStimulus();
    setAddr(5);
    ic.io_miss_start = 1'b1;
    applyStimulus();
    clearInputs();
    ic.io_ic_inv_all = 1'b1;
    applyStimulus();
    clearInputs();
    setAddr(20);
    #1;
    checkOutput("inv_busy", 32'(ic.io_busy), 32'd0);
    checkOutput("inv_valid20", 32'(ic.io_ic_tag_valid), 32'd0);
    ic.io_fill_done = 1'b1;
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("inv_no_wr", 32'(ic.io_ic_wr_en), 32'd0);
    applyStimulus();

    // Debug write to way1 in the same cycle as the fill write of way0
    runFill(9);
    ic.io_ic_debug_wr_en     = 1'b1;
    ic.io_ic_debug_tag_array = 1'b1;
    ic.io_ic_debug_way       = 2'b10;
    ic.io_ic_debug_addr      = 10'd9;
    ic.io_ic_debug_wr_data   = 71'd1;
    #1;
    checkOutput("dbg_fill_wr_en", 32'(ic.io_ic_wr_en), 32'd1);
    applyStimulus();
    clearInputs();
    setAddr(9);
    #1;
    checkOutput("dbg_fill_valid", 32'(ic.io_ic_tag_valid), 32'd3);
    applyStimulus();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      randomInputs();
      applyStimulus();
    end
    reset = 1'b0;
    clearInputs();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
